cdb_broadcaster: RTL
====================

// Module: cdb_broadcaster
// PURPOSE
//  Transmit side of the common data bus (CDB) that the RS lines, RS dispatch bypass and ROB snoop.
//  Each functional unit (FU) pushes completed results into a small per-FU FIFO.
//  A round-robin arbiter drains up to WAYS FIFO heads per cycle onto the CDB.
//  CDB outputs are registered and packed low: slot 0 first, e.g. 3'b001 when only one result is broadcast.
// PARAMETERS
//  WAYS        3   CDB slots broadcast per cycle
//  NUM_FU      6   result-producing FUs, one FIFO each
//  FIFO_DEPTH  2   entries per FU FIFO; power of 2, >= 2
//  XLEN        32  result data width
//  PRF         64  physical registers; tag width = $clog2(PRF)
//  ROB         16  ROB entries; ROB tag width = $clog2(ROB)
// PORTS
//  clock         in   1                      single clock, rising edge
//  reset         in   1                      asynchronous, active-low
//  squash        in   1                      synchronous flush, e.g. branch mispredict
//  fu_valid      in   NUM_FU                 FU i presents a result
//  fu_data       in   NUM_FU x XLEN          result value
//  fu_prf_idx    in   NUM_FU x $clog2(PRF)   destination PRF tag
//  fu_rob_idx    in   NUM_FU x $clog2(ROB)   ROB entry to mark complete
//  fu_ready      out  NUM_FU                 FIFO i can accept a result this cycle
//  CDB_valid     out  WAYS                   slot valid, packed low
//  CDB_Data      out  WAYS x XLEN            broadcast value
//  CDB_PRF_idx   out  WAYS x $clog2(PRF)     broadcast tag
//  CDB_rob_idx   out  WAYS x $clog2(ROB)     ROB tag to complete
// BEHAVIOUR
//  Reset (reset==0, async)
//   - All FIFOs empty; rr_ptr=0.
//   - CDB_valid/Data/PRF_idx/rob_idx all 0.
//   - fu_ready forced 0 while reset is low; it rises in the first cycle after release.
//  Push
//   - fu_ready[i] = (count[i] < FIFO_DEPTH).
//   - fu_ready gives no credit for a same-cycle pop, so a full FIFO drops ready for at least one cycle.
//   - A push occurs when fu_valid[i] && fu_ready[i]; it is written at the rising edge.
//   - fu_valid while !fu_ready is ignored. The FU must hold the result until ready.
//  Arbitration (combinational on FIFO heads, every cycle)
//   - Candidates are FIFOs with count > 0.
//   - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU. Grant the first min(WAYS, #candidates).
//   - The k-th grant drives slot k.
//  Pop and broadcast (at the rising edge)
//   - Granted heads pop; slot k registers {1, data, prf, rob}.
//   - Unused slots register {0, 0, 0, 0}.
//   - Minimum latency: result pushed at edge E appears on the CDB after edge E+1 (2-cycle push-to-CDB).
//   - CDB outputs hold for exactly one cycle per broadcast. No result is broadcast twice.
//  Round-robin
//   - rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
//   - No grant: rr_ptr unchanged.
//   - Any FU with a non-empty FIFO is granted within ceil(NUM_FU/WAYS) cycles.
//  Simultaneous push and pop on one FIFO
//   - Both occur; count is unchanged.
//   - The pointers wrap mod FIFO_DEPTH.
//   - A push into an empty FIFO is not visible to arbitration until the next cycle (no bypass).
//  Squash
//   - Takes priority over push and pop.
//   - At the edge: all counts and pointers = 0, CDB_valid <= 0, rr_ptr unchanged.
//   - Pushes in the squash cycle are discarded.
//   - fu_ready is unaffected by squash, because it follows count.
//  Reset mid-operation: all queued results are lost immediately; outputs go to reset values asynchronously.
//  Order: FIFO order per FU is preserved; no ordering between different FUs is guaranteed.
// TESTING
//  1. Single FU0 push {data=32'hDEAD_BEEF, prf=5, rob=3} at edge 1 -> after edge 2:
//     CDB_valid=3'b001, CDB_Data[0]=DEADBEEF, CDB_PRF_idx[0]=5, CDB_rob_idx[0]=3; all 0 next cycle.
//  2. FUs 0-5 all push together with rr_ptr=0 -> first broadcast grants FUs 0,1,2 (CDB_valid=3'b111), rr_ptr=3;
//     next cycle grants FUs 3,4,5, rr_ptr=0; then CDB_valid=0.
//  3. FU2 pushes every cycle while the other FUs idle -> FIFO never fills; one broadcast per cycle, in push order;
//     fu_ready[2] stays 1.
//  4. Fill FU1 to 2 entries with all FUs saturated -> fu_ready[1]=0; an extra fu_valid is ignored;
//     ready returns the cycle after a pop.
//  5. squash asserted with 4 queued results -> the next cycle has CDB_valid=0, all fu_ready=1,
//     and no stale result is ever broadcast.
//  6. Assert reset low asynchronously mid-broadcast -> CDB_valid=0 immediately, without waiting for a clock edge;
//     after release, the first push is broadcast with rr_ptr=0 ordering.

Source files
------------

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: per-FU result FIFOs drained by a round-robin arbiter
// onto WAYS registered broadcast slots, packed low (slot 0 first).
module cdb_broadcaster #(
  parameter int WAYS       = 3,
  parameter int NUM_FU     = 6,
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32,
  parameter int PRF        = 64,
  parameter int ROB        = 16
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     squash,
  input  logic [NUM_FU-1:0]                        fu_valid,
  input  logic [NUM_FU-1:0][XLEN-1:0]              fu_data,
  input  logic [NUM_FU-1:0][$clog2(PRF)-1:0]       fu_prf_idx,
  input  logic [NUM_FU-1:0][$clog2(ROB)-1:0]       fu_rob_idx,
  output logic [NUM_FU-1:0]                        fu_ready,
  output logic [WAYS-1:0]                          CDB_valid,
  output logic [WAYS-1:0][XLEN-1:0]                CDB_Data,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]         CDB_PRF_idx,
  output logic [WAYS-1:0][$clog2(ROB)-1:0]         CDB_rob_idx
);

  localparam int PW = $clog2(PRF);
  localparam int RW = $clog2(ROB);
  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // FIFO storage (data only, never reset) and its control
  logic [XLEN-1:0] mem_data_p0 [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0]   mem_prf_p0  [NUM_FU][FIFO_DEPTH];
  logic [RW-1:0]   mem_rob_p0  [NUM_FU][FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_p0   [NUM_FU];
  logic [AW-1:0]   rd_ptr_p0   [NUM_FU];
  logic [CW-1:0]   count_p0    [NUM_FU];
  logic [IW-1:0]   rr_ptr_p0;

  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] gnt;
  logic [WAYS-1:0]   slot_vld;
  logic [IW-1:0]     slot_fu   [WAYS];
  logic [XLEN-1:0]   slot_data [WAYS];
  logic [PW-1:0]     slot_prf  [WAYS];
  logic [RW-1:0]     slot_rob  [WAYS];
  logic [IW-1:0]     rr_next;

  // Registered broadcast slots
  logic [WAYS-1:0]           cdb_vld_p1;
  logic [WAYS-1:0][XLEN-1:0] cdb_data_p1;
  logic [WAYS-1:0][PW-1:0]   cdb_prf_p1;
  logic [WAYS-1:0][RW-1:0]   cdb_rob_p1;

  // Ready follows occupancy only (no credit for a same-cycle pop); held low in reset
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = reset && (count_p0[i] < CW'(FIFO_DEPTH));
      push[i]     = fu_valid[i] && fu_ready[i];
    end
  end

  // Round-robin scan from rr_ptr; the k-th non-empty FIFO found drives slot k
  always_comb begin
    int n;
    int sum;
    logic [IW-1:0] idx;
    gnt      = '0;
    slot_vld = '0;
    rr_next  = rr_ptr_p0;
    n        = 0;
    sum      = 0;
    idx      = '0;
    for (int k = 0; k < WAYS; k++) slot_fu[k] = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      sum = int'(rr_ptr_p0) + j;
      if (sum >= NUM_FU) sum = sum - NUM_FU;
      idx = IW'(sum);
      if ((count_p0[idx] != '0) && (n < WAYS)) begin
        gnt[idx] = 1'b1;
        for (int k = 0; k < WAYS; k++) begin
          if (k == n) begin
            slot_vld[k] = 1'b1;
            slot_fu[k]  = idx;
          end
        end
        rr_next = (sum == NUM_FU - 1) ? '0 : IW'(sum + 1);
        n = n + 1;
      end
    end
  end

  // Head-of-FIFO selection for each granted slot
  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      slot_data[k] = mem_data_p0[slot_fu[k]][rd_ptr_p0[slot_fu[k]]];
      slot_prf[k]  = mem_prf_p0[slot_fu[k]][rd_ptr_p0[slot_fu[k]]];
      slot_rob[k]  = mem_rob_p0[slot_fu[k]][rd_ptr_p0[slot_fu[k]]];
    end
  end

  // Stage p0: FIFO write port (pointers wrap naturally, depth is a power of 2)
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem_data_p0[i][wr_ptr_p0[i]] <= fu_data[i];
        mem_prf_p0[i][wr_ptr_p0[i]]  <= fu_prf_idx[i];
        mem_rob_p0[i][wr_ptr_p0[i]]  <= fu_rob_idx[i];
      end
    end
  end

  // Stage p0: FIFO pointers, occupancy and arbitration pointer; squash empties all FIFOs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_p0 <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_p0[i] <= '0;
        rd_ptr_p0[i] <= '0;
        count_p0[i]  <= '0;
      end
    end else if (squash) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_p0[i] <= '0;
        rd_ptr_p0[i] <= '0;
        count_p0[i]  <= '0;
      end
    end else begin
      rr_ptr_p0 <= rr_next;
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr_p0[i] <= wr_ptr_p0[i] + 1'b1;
        if (gnt[i])  rd_ptr_p0[i] <= rd_ptr_p0[i] + 1'b1;
        if (push[i] && !gnt[i])      count_p0[i] <= count_p0[i] + 1'b1;
        else if (gnt[i] && !push[i]) count_p0[i] <= count_p0[i] - 1'b1;
      end
    end
  end

  // Stage p1: registered CDB slots, zero when unused or squashed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_vld_p1  <= '0;
      cdb_data_p1 <= '0;
      cdb_prf_p1  <= '0;
      cdb_rob_p1  <= '0;
    end else if (squash) begin
      cdb_vld_p1  <= '0;
      cdb_data_p1 <= '0;
      cdb_prf_p1  <= '0;
      cdb_rob_p1  <= '0;
    end else begin
      cdb_vld_p1 <= slot_vld;
      for (int k = 0; k < WAYS; k++) begin
        cdb_data_p1[k] <= slot_vld[k] ? slot_data[k] : '0;
        cdb_prf_p1[k]  <= slot_vld[k] ? slot_prf[k]  : '0;
        cdb_rob_p1[k]  <= slot_vld[k] ? slot_rob[k]  : '0;
      end
    end
  end

  assign CDB_valid   = cdb_vld_p1;
  assign CDB_Data    = cdb_data_p1;
  assign CDB_PRF_idx = cdb_prf_p1;
  assign CDB_rob_idx = cdb_rob_p1;

endmodule
